// File: rtl/tread_pkg.sv
// Shared types and mapping functions for the joystick-to-tread converter.
// Tread directions, the per-player A/B target pair and the reversal-filter states.
package tread_pkg;

  typedef enum logic [1:0] {
    STOP = 2'd0,
    FW   = 2'd1,
    BK   = 2'd2
  } tread_dir_t;

  typedef struct packed {
    tread_dir_t a;
    tread_dir_t b;
  } tread_pair_t;

  typedef enum logic {
    RUN  = 1'b0,
    DEAD = 1'b1
  } filt_state_t;

  // Stick vector is {up, down, left, right}.
  function automatic tread_pair_t map_single(input logic [3:0] udlr);
    tread_pair_t r;
    case (udlr)
      4'b1010: r = '{a: STOP, b: FW};
      4'b1000: r = '{a: FW,   b: FW};
      4'b1001: r = '{a: FW,   b: STOP};
      4'b0001: r = '{a: FW,   b: BK};
      4'b0101: r = '{a: BK,   b: STOP};
      4'b0100: r = '{a: BK,   b: BK};
      4'b0110: r = '{a: STOP, b: BK};
      4'b0010: r = '{a: BK,   b: FW};
      default: r = '{a: STOP, b: STOP};
    endcase
    return r;
  endfunction

  function automatic tread_pair_t map_direct(input logic [3:0] udlr);
    tread_pair_t r;
    r.a = STOP;
    r.b = STOP;
    if (udlr[3] && !udlr[2]) r.a = FW;
    else if (udlr[2] && !udlr[3]) r.a = BK;
    if (udlr[1] && !udlr[0]) r.b = FW;
    else if (udlr[0] && !udlr[1]) r.b = BK;
    return r;
  endfunction

  function automatic logic is_reversal(input tread_dir_t cur, input tread_dir_t tgt);
    return ((cur == FW) && (tgt == BK)) || ((cur == BK) && (tgt == FW));
  endfunction

endpackage

// File: rtl/tread_joy_chan.sv
// One player channel: 2-flop synchroniser, debounce, stick-to-tread map and
// one reversal dead-time filter per tread (index 0 = tread A, 1 = tread B).
module tread_joy_chan
  import tread_pkg::*;
#(
  parameter int unsigned DEBOUNCE = 4,
  parameter int unsigned DEADTIME = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ce,
  input  logic [3:0] joy_in,
  input  logic       mode,
  output logic       tread_a_fw,
  output logic       tread_a_bk,
  output logic       tread_b_fw,
  output logic       tread_b_bk,
  output logic       busy
);

  localparam logic [CNT_W-1:0] DEB_MAX  = CNT_W'(DEBOUNCE);
  localparam logic [CNT_W-1:0] DEAD_MAX = CNT_W'(DEADTIME);

  logic [3:0]       sync1_q, sync2_q;
  logic [3:0]       cand_q, cand_d;
  logic [3:0]       acc_q, acc_d;
  logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;

  tread_pair_t      pair;
  tread_dir_t       tgt    [2];
  tread_dir_t       out_q  [2];
  filt_state_t      st_q   [2];
  logic [CNT_W-1:0] dead_cnt_q [2];

  // A new vector reloads the candidate regardless of ce; only the hold count waits on ce.
  always_comb begin
    cand_d    = cand_q;
    deb_cnt_d = deb_cnt_q;
    acc_d     = acc_q;
    if (sync2_q != cand_q) begin
      cand_d    = sync2_q;
      deb_cnt_d = CNT_W'(1);
    end else if (ce && (deb_cnt_q < DEB_MAX)) begin
      deb_cnt_d = deb_cnt_q + 1'b1;
    end
    if (deb_cnt_d == DEB_MAX) acc_d = cand_d;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      cand_q    <= '0;
      acc_q     <= '0;
      deb_cnt_q <= '0;
    end else begin
      sync1_q   <= joy_in;
      sync2_q   <= sync1_q;
      cand_q    <= cand_d;
      acc_q     <= acc_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  always_comb begin
    pair   = mode ? map_direct(acc_q) : map_single(acc_q);
    tgt[0] = pair.a;
    tgt[1] = pair.b;
  end

  // DEAD exits early only to STOP; a target flipping back keeps the full dead time.
  always_ff @(posedge clk_sys) begin
    for (int t = 0; t < 2; t++) begin
      if (reset) begin
        st_q[t]       <= RUN;
        out_q[t]      <= STOP;
        dead_cnt_q[t] <= '0;
      end else begin
        case (st_q[t])
          RUN: begin
            if ((DEADTIME > 0) && is_reversal(out_q[t], tgt[t])) begin
              out_q[t]      <= STOP;
              dead_cnt_q[t] <= '0;
              st_q[t]       <= DEAD;
            end else begin
              out_q[t] <= tgt[t];
            end
          end
          DEAD: begin
            if (tgt[t] == STOP) begin
              st_q[t] <= RUN;
            end else if (ce) begin
              if ((dead_cnt_q[t] + 1'b1) == DEAD_MAX) begin
                out_q[t] <= tgt[t];
                st_q[t]  <= RUN;
              end
              dead_cnt_q[t] <= dead_cnt_q[t] + 1'b1;
            end
          end
          default: begin
            st_q[t]  <= RUN;
            out_q[t] <= STOP;
          end
        endcase
      end
    end
  end

  assign tread_a_fw = (out_q[0] == FW);
  assign tread_a_bk = (out_q[0] == BK);
  assign tread_b_fw = (out_q[1] == FW);
  assign tread_b_bk = (out_q[1] == BK);
  assign busy       = (st_q[0] == DEAD) || (st_q[1] == DEAD);

endmodule

// File: rtl/tread_joy_mapper.sv
// Multi-player 8-way joystick to dual-tread converter; one channel per player,
// the top level only slices the per-player buses.
module tread_joy_mapper
  import tread_pkg::*;
#(
  parameter int unsigned PLAYERS  = 2,
  parameter int unsigned DEBOUNCE = 4,
  parameter int unsigned DEADTIME = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic                   ce,
  input  logic [4*PLAYERS-1:0]   joy_in,
  input  logic [PLAYERS-1:0]     mode,
  output logic [PLAYERS-1:0]     tread_a_fw,
  output logic [PLAYERS-1:0]     tread_a_bk,
  output logic [PLAYERS-1:0]     tread_b_fw,
  output logic [PLAYERS-1:0]     tread_b_bk,
  output logic [PLAYERS-1:0]     busy
);

  for (genvar p = 0; p < PLAYERS; p++) begin : g_player
    tread_joy_chan #(
      .DEBOUNCE (DEBOUNCE),
      .DEADTIME (DEADTIME),
      .CNT_W    (CNT_W)
    ) u_chan (
      .clk_sys    (clk_sys),
      .reset      (reset),
      .ce         (ce),
      .joy_in     (joy_in[4*p +: 4]),
      .mode       (mode[p]),
      .tread_a_fw (tread_a_fw[p]),
      .tread_a_bk (tread_a_bk[p]),
      .tread_b_fw (tread_b_fw[p]),
      .tread_b_bk (tread_b_bk[p]),
      .busy       (busy[p])
    );
  end

endmodule

// File: tb/tb_tread_joy_mapper.sv
// Directed bench for tread_joy_mapper: stimulus pushes {cycle, outputs} expectations,
// a monitor pops one per observed output change and compares value and cycle.
module tb_tread_joy_mapper;

  localparam int PLAYERS  = 2;
  localparam int DEBOUNCE = 4;
  localparam int DEADTIME = 8;
  localparam int CNT_W    = 8;
  localparam int W        = 42;

  logic                 clk_sys = 1'b0;
  logic                 reset;
  logic                 ce;
  logic [4*PLAYERS-1:0] joy_in;
  logic [PLAYERS-1:0]   mode;
  logic [PLAYERS-1:0]   tread_a_fw, tread_a_bk, tread_b_fw, tread_b_bk, busy;

  tread_joy_mapper #(
    .PLAYERS  (PLAYERS),
    .DEBOUNCE (DEBOUNCE),
    .DEADTIME (DEADTIME),
    .CNT_W    (CNT_W)
  ) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .ce         (ce),
    .joy_in     (joy_in),
    .mode       (mode),
    .tread_a_fw (tread_a_fw),
    .tread_a_bk (tread_a_bk),
    .tread_b_fw (tread_b_fw),
    .tread_b_bk (tread_b_bk),
    .busy       (busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  // per player {busy, b_bk, b_fw, a_bk, a_fw}; player 1 in the upper 5 bits
  logic [9:0] bundle;
  assign bundle = {busy[1], tread_b_bk[1], tread_b_fw[1], tread_a_bk[1], tread_a_fw[1],
                   busy[0], tread_b_bk[0], tread_b_fw[0], tread_a_bk[0], tread_a_fw[0]};

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           checks = 0;
  int           errors = 0;
  logic         mon_en = 1'b0;
  logic [9:0]   prev   = '0;

  function automatic logic [W-1:0] mk(input int c, input logic [9:0] v);
    return {c[31:0], v};
  endfunction

  always @(negedge clk_sys) begin
    logic [W-1:0] e;
    if (mon_en && (bundle != prev)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change cyc=%0d got=%b required=%b (no change)", cyc, bundle, prev);
      end else begin
        e = exp_q.pop_front();
        if ((e[W-1:10] != 32'(cyc)) || (e[9:0] != bundle)) begin
          errors++;
          $display("FAIL out_change got=%b at cyc %0d required=%b at cyc %0d",
                   bundle, cyc, e[9:0], e[W-1:10]);
        end
      end
      prev = bundle;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_sys);
  endtask

  task automatic set_joy(input int p, input logic [3:0] v, output int base);
    @(posedge clk_sys);
    #1;
    joy_in[4*p +: 4] = v;
    base = cyc;
  endtask

  task automatic set_mode(input int p, input logic v, output int base);
    @(posedge clk_sys);
    #1;
    mode[p] = v;
    base = cyc;
  endtask

  localparam int LAT = DEBOUNCE + 3;

  // ---------------- stimulus ----------------
  initial begin
    int b;
    int b2;
    reset  = 1'b1;
    ce     = 1'b1;
    joy_in = '0;
    mode   = 2'b10;
    wait_cyc(3);
    #1;
    checks++;
    if (bundle != 10'b0) begin
      errors++;
      $display("FAIL reset_state got=%b required=%b", bundle, 10'b0);
    end
    reset  = 1'b0;
    prev   = '0;
    mon_en = 1'b1;
    wait_cyc(4);

    // 3-sample glitch on player 0 must never be accepted
    set_joy(0, 4'b0100, b);
    wait_cyc(2);
    set_joy(0, 4'b0000, b);
    wait_cyc(15);

    // up: both treads forward
    set_joy(0, 4'b1000, b);
    exp_q.push_back(mk(b + LAT, 10'b00000_00101));
    wait_cyc(12);

    // down: reversal on both treads, dead time then both back
    set_joy(0, 4'b0100, b);
    exp_q.push_back(mk(b + LAT, 10'b00000_10000));
    exp_q.push_back(mk(b + LAT + DEADTIME, 10'b00000_01010));
    wait_cyc(20);

    // reverse again, then release the stick mid dead time
    set_joy(0, 4'b1000, b);
    exp_q.push_back(mk(b + LAT, 10'b00000_10000));
    wait_cyc(5);
    set_joy(0, 4'b0000, b2);
    exp_q.push_back(mk(b2 + LAT, 10'b00000_00000));
    wait_cyc(15);

    // back from stop: no reversal
    set_joy(0, 4'b0100, b);
    exp_q.push_back(mk(b + LAT, 10'b00000_01010));
    wait_cyc(12);

    // reverse to up, return to down mid dead time: full dead time then down
    set_joy(0, 4'b1000, b);
    exp_q.push_back(mk(b + LAT, 10'b00000_10000));
    wait_cyc(7);
    set_joy(0, 4'b0100, b2);
    exp_q.push_back(mk(b + LAT + DEADTIME, 10'b00000_01010));
    wait_cyc(20);

    // player 1 direct mode, player 0 held at (BK,BK)
    set_joy(1, 4'b1001, b);
    exp_q.push_back(mk(b + LAT, 10'b01001_01010));
    wait_cyc(12);
    set_joy(1, 4'b1100, b);
    exp_q.push_back(mk(b + LAT, 10'b00000_01010));
    wait_cyc(12);
    set_joy(1, 4'b0110, b);
    exp_q.push_back(mk(b + LAT, 10'b00110_01010));
    wait_cyc(12);

    // mode flip to single-stick: A stops, B reverses FW->BK
    set_mode(1, 1'b0, b);
    exp_q.push_back(mk(b + 1, 10'b10000_01010));
    exp_q.push_back(mk(b + 1 + DEADTIME, 10'b01000_01010));
    wait_cyc(16);

    // ce one clock in four: acceptance waits on ce-qualified samples
    set_joy(0, 4'b0000, b);
    exp_q.push_back(mk(b + 16, 10'b01000_00000));
    for (int k = 1; k <= 16; k++) begin
      ce = ((k % 4) == 3);
      @(posedge clk_sys);
      #1;
    end
    ce = 1'b1;
    wait_cyc(6);

    // reset in the middle of a dead time
    set_joy(0, 4'b1000, b);
    exp_q.push_back(mk(b + LAT, 10'b01000_00101));
    wait_cyc(10);
    set_joy(0, 4'b0100, b);
    exp_q.push_back(mk(b + LAT, 10'b01000_10000));
    exp_q.push_back(mk(b + 10, 10'b00000_00000));
    wait_cyc(9);
    #1;
    reset  = 1'b1;
    joy_in = '0;
    wait_cyc(2);
    #1;
    reset = 1'b0;
    wait_cyc(20);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain got=%0d pending required=0 (next at cyc %0d)",
               exp_q.size(), exp_q[0][W-1:10]);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
